// File: rtl/mdu_pkg.sv
// Shared MDU op-code constants and op-class decode helpers.
// Optional accumulate ops (7-10) are decoded only when MDU_MADD_EN is defined.
package mdu_defs;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } mdu_state_t;

    function automatic logic is_mult_class(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return op inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
`else
        return op inside {MDU_MULT, MDU_MULTU};
`endif
    endfunction

    function automatic logic is_div_class(input logic [3:0] op);
        return op inside {MDU_DIV, MDU_DIVU};
    endfunction

endpackage

// File: rtl/mdu.sv
// Fixed-latency multiply/divide unit owning the HI/LO registers.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             accept, done;

    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && is_mult_class(op)) begin
                    accept   = 1'b1;
                    cnt_nx   = CNT_W'(MULT_CYCLES);
                    state_nx = S_RUN;
                end else if (start && is_div_class(op)) begin
                    accept   = 1'b1;
                    cnt_nx   = CNT_W'(DIV_CYCLES);
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    done     = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign busy = (state == S_RUN);

    // NOTE: captured operands are only consumed after a load, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op;
            a_q  <= rs_data;
            b_q  <= rt_data;
        end
    end

    logic        mul_signed, div_signed;
    logic [63:0] a_ext, b_ext, prod, mult_result;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    always_comb begin
        mul_signed = op_q inside {MDU_MULT, MDU_MADD, MDU_MSUB};
        a_ext      = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b_ext      = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod       = a_ext * b_ext;

        // Signed divide works on magnitudes, then restores the C-style signs.
        div_signed = (op_q == MDU_DIV);
        a_mag      = (div_signed && a_q[31]) ? -a_q : a_q;
        b_mag      = (div_signed && b_q[31]) ? -b_q : b_q;
        q_mag      = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
        r_mag      = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
        quot       = (div_signed && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
        rem        = (div_signed && a_q[31]) ? -r_mag : r_mag;

`ifdef MDU_MADD_EN
        case (op_q)
            MDU_MADD, MDU_MADDU: mult_result = {hi, lo} + prod;
            MDU_MSUB, MDU_MSUBU: mult_result = {hi, lo} - prod;
            default:             mult_result = prod;
        endcase
`else
        mult_result = prod;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            if (is_div_class(op_q)) begin
                if (b_q != 32'd0) begin
                    hi <= rem;
                    lo <= quot;
                end
            end else begin
                {hi, lo} <= mult_result;
            end
        end else if (state == S_IDLE && start && op == MDU_MTHI) begin
            hi <= rs_data;
        end else if (state == S_IDLE && start && op == MDU_MTLO) begin
            lo <= rs_data;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus random ops against
// an arithmetic reference model of HI/LO and busy duration.
module tb_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int passed = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Architectural effect of one op on the expected HI/LO; returns busy cycles.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
        logic [63:0] p, acc;
        longint sa, sb, sq, sr;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        acc = {exp_hi, exp_lo};
        cyc = 0;
        case (o)
            4'd1: begin p = sa * sb; {exp_hi, exp_lo} = p; cyc = MULT_N; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; {exp_hi, exp_lo} = p; cyc = MULT_N; end
            4'd3: begin
                if (b != 0) begin
                    sq = sa / sb; sr = sa % sb;
                    exp_lo = sq[31:0]; exp_hi = sr[31:0];
                end
                cyc = DIV_N;
            end
            4'd4: begin
                if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
                cyc = DIV_N;
            end
            4'd5: exp_hi = a;
            4'd6: exp_lo = a;
`ifdef MDU_MADD_EN
            4'd7:  begin p = sa * sb; {exp_hi, exp_lo} = acc + p; cyc = MULT_N; end
            4'd8:  begin p = {32'd0, a} * {32'd0, b}; {exp_hi, exp_lo} = acc + p; cyc = MULT_N; end
            4'd9:  begin p = sa * sb; {exp_hi, exp_lo} = acc - p; cyc = MULT_N; end
            4'd10: begin p = {32'd0, a} * {32'd0, b}; {exp_hi, exp_lo} = acc - p; cyc = MULT_N; end
`endif
            default: cyc = 0;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int n, exp_n;
        model(o, a, b, exp_n);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0; op = 4'($urandom); rs_data = $urandom; rt_data = $urandom;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(exp_n));
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int n, exp_n;
        logic [31:0] ra, rb;

        #1 reset = 1'b1;
        #2;
        check("reset busy", 64'(busy), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        run_op("div_neg7_2", 4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_neg7_2 lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        run_op("divu_neg7_2", 4'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("mthi", 4'd5, 32'h1234_5678, 32'd0);
        run_op("div_by_zero", 4'd3, 32'h0000_1234, 32'd0);
        run_op("div_overflow", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("none_op", 4'd0, 32'hDEAD_BEEF, 32'd3);
        run_op("op15", 4'd15, 32'hDEAD_BEEF, 32'd3);

        // Second start during busy must be ignored.
        model(4'd1, 32'hFFFF_FFFF, 32'd1, exp_n);
        @(negedge clk);
        start = 1'b1; op = 4'd1; rs_data = 32'hFFFF_FFFF; rt_data = 32'd1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 2) begin
                start = 1'b1; op = 4'd6; rs_data = 32'hAAAA_0000; rt_data = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("start_while_busy busy_cycles", 64'(n), 64'(exp_n));
        check("start_while_busy hi", 64'(hi), 64'(exp_hi));
        check("start_while_busy lo", 64'(lo), 64'(exp_lo));

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; op = 4'd3; rs_data = 32'd100; rt_data = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("async_reset busy", 64'(busy), 64'(0));
        check("async_reset hi", 64'(hi), 64'(0));
        check("async_reset lo", 64'(lo), 64'(0));
        #1 reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        repeat (15) @(negedge clk);
        check("post_reset busy", 64'(busy), 64'(0));
        check("post_reset hi", 64'(hi), 64'(0));
        check("post_reset lo", 64'(lo), 64'(0));

        run_op("acc_mthi", 4'd5, 32'd0, 32'd0);
        run_op("acc_mtlo", 4'd6, 32'hFFFF_FFFF, 32'd0);
        run_op("maddu_1x1", 4'd8, 32'd1, 32'd1);
        run_op("msub_neg", 4'd9, 32'hFFFF_FFFE, 32'd3);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            run_op($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), ra, rb);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the EX stage, beside the ALU and barrel shifter. It accepts one MDU instruction per start pulse and computes signed or unsigned multiply and divide over a fixed multi-cycle latency. It owns the architectural HI/LO registers. It asserts `busy` so the hazard unit can stall later MDU instructions and the MFHI/MFLO reads that depend on them.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for multiply ops (≥1).
- `DIV_CYCLES`, 10: busy cycles for divide ops (≥1).

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: op valid this cycle; sampled on the rising edge.
- `op`  in  4: operation code, see Operation.
- `rs_data`  in  32: operand A; for MTHI/MTLO, the source value.
- `rt_data`  in  32: operand B.
- `busy`  out  1: computation in flight.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation
Op codes:
- 0: NONE.
- 1: MULT.
- 2: MULTU.
- 3: DIV.
- 4: DIVU.
- 5: MTHI.
- 6: MTLO.
- 7–10: MADD, MADDU, MSUB, MSUBU (only with `MDU_MADD_EN`).
- Codes 11–15 and unconfigured codes are NONE.

States:
- IDLE: `busy`=0.
- RUN: `busy`=1, down-counter `cnt`.

Transitions:
- IDLE with `start` and a mult-class op: capture operands and op, `cnt`←`MULT_CYCLES`, go to RUN.
- IDLE with `start` and a div-class op: as above, but `cnt`←`DIV_CYCLES`.
- RUN: `cnt` decrements every edge.
- RUN with `cnt`==1: write HI/LO and go to IDLE on that edge.

Results:
- MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product of captured A×B.
- DIV/DIVU: LO = quotient, HI = remainder. The quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (captured B==0): HI/LO are left unchanged, but the full `DIV_CYCLES` busy period still elapses.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: write HI/LO from `rs_data` on the sampling edge; no busy cycles; accepted only in IDLE.

`start` while `busy`=1 is ignored: no state change, and the in-flight op is unaffected. Upstream must stall on `start & mdu_op | busy`.

Operands are captured at start. Input changes during RUN have no effect.

## Timing
- Reset: `busy`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0, applied immediately regardless of clock.
- Reset mid-RUN aborts the op; no HI/LO write follows.
- Latency: with `start` sampled at edge E0, `busy` is 1 from just after E0 through edge E0+N, where N is the op's cycle parameter.
- HI/LO take the result at edge E0+N, the same edge `busy` falls.
- A new `start` is accepted at edge E0+N+1 at the earliest. Back-to-back at E0+N is impossible, because `busy`=1 in the preceding cycle.
- MTHI/MTLO: new value visible in the cycle after the sampling edge.
- `hi`/`lo` are driven directly from registers; there is no bypass of in-flight results.

## Configuration
- Macro `MDU_MADD_EN`.
- Defined: ops 7–10 are decoded as mult-class with `MULT_CYCLES` latency. The final write is {HI,LO} ← {HI,LO} ± product (signed for MADD/MSUB, unsigned for MADDU/MSUBU), using 64-bit wrap-around arithmetic. The {HI,LO} value used is the one read at the write edge.
- Undefined: ops 7–10 are NONE. No accumulator adder is synthesized.

## Structure
- Package `mdu_defs`: the 4-bit op code constants, `MDU_NONE`…`MDU_MSUBU`, shared with the decoder in the ID stage and the hazard unit.
- Also in `mdu_defs`: the `is_mult_class`/`is_div_class` helper encodings.
- No sub-module required. Control (state and `cnt`) and the datapath (captured operands, result compute, HI/LO registers) stay in one module.

## Test plan
- MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF -> `busy` high for exactly 5 cycles; then HI=0xFFFFFFFE, LO=0x00000001.
- DIV with A=0xFFFFFFF9 (−7), B=2 -> `busy` for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
- MTHI with `rs_data`=0x12345678 in IDLE -> `hi`=0x12345678 next cycle, `busy` stays 0. Then DIV with B=0 -> 10 busy cycles, HI/LO unchanged.
- MULT of −1×1 started; at busy cycle 2, issue `start` with MTLO 0xAAAA0000 -> the second start is ignored, and the final HI=LO=0xFFFFFFFF.
- Assert `reset` asynchronously at busy cycle 3 of a DIV -> `busy`, `hi`, `lo` go to 0 immediately, and no write occurs later.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then MADDU of 1×1 -> HI=1, LO=0. Without the macro, the same op leaves HI/LO unchanged and `busy` stays 0.
